m_ctrl_fsm: RTL and testbench

Multicycle MIPS control unit. It sits directly upstream of the multicycle datapath and drives every datapath control input.
- Decodes the instruction-register contents, `Inst`, that the datapath feeds back, plus its `zero`/`overflow` flags.
- Sequences fetch, decode, execute, memory and write-back as a Moore FSM.
- Stalls on `MIO_ready` and reports overflow and illegal-opcode events.

---
 rtl/m_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_m_ctrl_fsm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ctrl_fsm.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute,
// memory and write-back. It drives every datapath control input from the IR fields.
module m_ctrl_fsm #(
   parameter bit P_NOP_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Inst,
   input  logic        zero,
   input  logic        overflow,
   input  logic        MIO_ready,
   output logic        IorD,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        Branch,
   output logic        Shift,
   output logic [1:0]  RegDst,
   output logic [1:0]  MemtoReg,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic [2:0]  ALU_operation,
   output logic        mem_r,
   output logic        mem_w,
   output logic [3:0]  state_out,
   output logic        ovf_exc,
   output logic        illegal_inst
);

   typedef enum logic [3:0] {
      S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
      S_LWB = 4'd4,  S_MWR = 4'd5,  S_REX = 4'd6,  S_RWB = 4'd7,
      S_BR  = 4'd8,  S_J   = 4'd9,  S_IEX = 4'd10, S_IWB = 4'd11,
      S_LUI = 4'd12, S_JAL = 4'd13, S_JR  = 4'd14, S_ERR = 4'd15
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                          ALU_XOR = 3'b011, ALU_NOR = 3'b100, ALU_SRL = 3'b101,
                          ALU_SUB = 3'b110, ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                          OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                          OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

   localparam logic [5:0] F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22,
                          F_AND = 6'h24, F_OR  = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                          F_SLT = 6'h2A;

   state_t      state_q, state_d;
   logic        ovf_q, ovf_d;
   logic        ill_q, ill_d;
   logic [5:0]  op, funct;
   logic [2:0]  rex_alu, iex_alu;
   logic        rex_shift, rex_valid, rex_ovf_chk;
   state_t      ill_next;
   logic        unused_inputs;

   assign op            = Inst[31:26];
   assign funct         = Inst[5:0];
   assign ill_next      = P_NOP_ON_ILLEGAL ? S_IF : S_ERR;
   assign unused_inputs = ^{Inst[25:6], zero};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
         ovf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      rex_alu     = ALU_AND;
      rex_shift   = 1'b0;
      rex_valid   = 1'b1;
      rex_ovf_chk = 1'b0;
      case (funct)
         F_ADD:   begin rex_alu = ALU_ADD; rex_ovf_chk = 1'b1; end
         F_SUB:   begin rex_alu = ALU_SUB; rex_ovf_chk = 1'b1; end
         F_AND:   rex_alu = ALU_AND;
         F_OR:    rex_alu = ALU_OR;
         F_XOR:   rex_alu = ALU_XOR;
         F_NOR:   rex_alu = ALU_NOR;
         F_SLT:   rex_alu = ALU_SLT;
         F_SRL:   begin rex_alu = ALU_SRL; rex_shift = 1'b1; end
         default: rex_valid = 1'b0;
      endcase
   end

   always_comb begin
      iex_alu = ALU_AND;
      case (op)
         OP_ADDI: iex_alu = ALU_ADD;
         OP_SLTI: iex_alu = ALU_SLT;
         OP_ANDI: iex_alu = ALU_AND;
         OP_ORI:  iex_alu = ALU_OR;
         default: iex_alu = ALU_AND;
      endcase
   end

   // Only ADD, SUB and ADDI can suppress write-back; SLT/SLTI overflow is meaningless.
   always_comb begin
      state_d = state_q;
      ovf_d   = ovf_q;
      ill_d   = 1'b0;
      case (state_q)
         S_IF:  if (MIO_ready) state_d = S_ID;
         S_ID: begin
            case (op)
               OP_LW, OP_SW:                      state_d = S_MA;
               OP_RTYPE:                          state_d = (funct == F_JR) ? S_JR : S_REX;
               OP_BEQ, OP_BNE:                    state_d = S_BR;
               OP_J:                              state_d = S_J;
               OP_JAL:                            state_d = S_JAL;
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEX;
               OP_LUI:                            state_d = S_LUI;
               default: begin
                  ill_d   = 1'b1;
                  state_d = ill_next;
               end
            endcase
         end
         S_MA:  state_d = (op == OP_SW) ? S_MWR : S_MRD;
         S_MRD: if (MIO_ready) state_d = S_LWB;
         S_MWR: if (MIO_ready) state_d = S_IF;
         S_REX: begin
            ovf_d = overflow & rex_ovf_chk;
            if (rex_valid) begin
               state_d = S_RWB;
            end else begin
               ill_d   = 1'b1;
               state_d = ill_next;
            end
         end
         S_IEX: begin
            ovf_d   = overflow & (op == OP_ADDI);
            state_d = S_IWB;
         end
         S_LWB, S_RWB, S_IWB, S_BR, S_J, S_JAL, S_JR, S_LUI: state_d = S_IF;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      Branch        = 1'b0;
      Shift         = 1'b0;
      RegDst        = 2'b00;
      MemtoReg      = 2'b00;
      ALUSrcB       = 2'b00;
      PCSource      = 2'b00;
      ALU_operation = ALU_AND;
      mem_r         = 1'b0;
      mem_w         = 1'b0;
      ovf_exc       = 1'b0;
      case (state_q)
         S_IF: begin
            mem_r = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'b01;
            ALU_operation = ALU_ADD; PCWrite = 1'b1;
         end
         S_ID:  begin ALUSrcB = 2'b11; ALU_operation = ALU_ADD; end
         S_MA:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = ALU_ADD; end
         S_MRD: begin IorD = 1'b1; mem_r = 1'b1; end
         S_LWB: begin RegWrite = 1'b1; MemtoReg = 2'b01; end
         S_MWR: begin IorD = 1'b1; mem_w = 1'b1; end
         S_REX: begin ALUSrcA = 1'b1; ALU_operation = rex_alu; Shift = rex_shift; end
         S_RWB: begin RegDst = 2'b01; RegWrite = ~ovf_q; ovf_exc = ovf_q; end
         S_IEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = iex_alu; end
         S_IWB: begin RegWrite = ~ovf_q; ovf_exc = ovf_q; end
         S_BR: begin
            ALUSrcA = 1'b1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1;
            PCSource = 2'b01; Branch = (op == OP_BEQ);
         end
         S_J:   begin PCSource = 2'b10; PCWrite = 1'b1; end
         S_JAL: begin
            RegDst = 2'b10; MemtoReg = 2'b11; RegWrite = 1'b1;
            PCSource = 2'b10; PCWrite = 1'b1;
         end
         S_JR:  begin PCSource = 2'b11; PCWrite = 1'b1; end
         S_LUI: begin MemtoReg = 2'b10; RegWrite = 1'b1; end
         default: ;
      endcase
   end

   assign illegal_inst = ill_q;
   assign state_out    = state_q;

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// Scoreboard bench for m_ctrl_fsm: a driver walks each instruction through its expected
// state path, pushing the expected output vector per cycle; a monitor pops and compares.
module tb_m_ctrl_fsm;

   typedef struct packed {
      logic       iord, irwrite, regwrite, alusrca, pcwrite, pcwritecond, branch, shift;
      logic [1:0] regdst, memtoreg, alusrcb, pcsource;
      logic [2:0] aluop;
      logic       mem_r, mem_w;
      logic [3:0] state;
      logic       ovf_exc, illegal;
   } outv_t;

   logic        clk = 1'b0;
   logic        reset, zero, overflow, MIO_ready;
   logic [31:0] Inst;

   logic IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, Shift;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
   logic [2:0] ALU_operation;
   logic mem_r, mem_w, ovf_exc, illegal_inst;
   logic [3:0] state_out;

   logic e_IorD, e_IRWrite, e_RegWrite, e_ALUSrcA, e_PCWrite, e_PCWriteCond, e_Branch, e_Shift;
   logic [1:0] e_RegDst, e_MemtoReg, e_ALUSrcB, e_PCSource;
   logic [2:0] e_ALU_operation;
   logic e_mem_r, e_mem_w, e_ovf_exc, e_illegal_inst;
   logic [3:0] e_state_out;

   outv_t act;
   outv_t exp_q[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   bit    ovf_m = 1'b0;
   bit    ill_pend = 1'b0;
   int    err_chk = -1;
   bit    err_ill = 1'b0;

   always #5 clk = ~clk;

   m_ctrl_fsm dut (
      .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow),
      .MIO_ready(MIO_ready), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
      .Shift(Shift), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .ALU_operation(ALU_operation), .mem_r(mem_r), .mem_w(mem_w),
      .state_out(state_out), .ovf_exc(ovf_exc), .illegal_inst(illegal_inst)
   );

   m_ctrl_fsm #(.P_NOP_ON_ILLEGAL(1'b0)) dut_err (
      .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow),
      .MIO_ready(MIO_ready), .IorD(e_IorD), .IRWrite(e_IRWrite), .RegWrite(e_RegWrite),
      .ALUSrcA(e_ALUSrcA), .PCWrite(e_PCWrite), .PCWriteCond(e_PCWriteCond), .Branch(e_Branch),
      .Shift(e_Shift), .RegDst(e_RegDst), .MemtoReg(e_MemtoReg), .ALUSrcB(e_ALUSrcB),
      .PCSource(e_PCSource), .ALU_operation(e_ALU_operation), .mem_r(e_mem_r), .mem_w(e_mem_w),
      .state_out(e_state_out), .ovf_exc(e_ovf_exc), .illegal_inst(e_illegal_inst)
   );

   assign act = {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, Shift,
                 RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation, mem_r, mem_w,
                 state_out, ovf_exc, illegal_inst};

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit funct_ok(input logic [5:0] fn);
      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};
   endfunction

   // Expected control vector for one cycle, straight from the per-state output table.
   function automatic outv_t exp_out(input int st, input logic [31:0] ins, input bit ovf, input bit ill);
      outv_t v;
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      v = '0;
      v.state = st[3:0];
      v.illegal = ill;
      case (st)
         0:  begin v.mem_r = 1; v.irwrite = 1; v.alusrcb = 2'b01; v.aluop = 3'b010; v.pcwrite = 1; end
         1:  begin v.alusrcb = 2'b11; v.aluop = 3'b010; end
         2:  begin v.alusrca = 1; v.alusrcb = 2'b10; v.aluop = 3'b010; end
         3:  begin v.iord = 1; v.mem_r = 1; end
         4:  begin v.regwrite = 1; v.memtoreg = 2'b01; end
         5:  begin v.iord = 1; v.mem_w = 1; end
         6: begin
            v.alusrca = 1;
            case (fn)
               6'h20: v.aluop = 3'b010;
               6'h22: v.aluop = 3'b110;
               6'h24: v.aluop = 3'b000;
               6'h25: v.aluop = 3'b001;
               6'h26: v.aluop = 3'b011;
               6'h27: v.aluop = 3'b100;
               6'h2A: v.aluop = 3'b111;
               6'h02: begin v.aluop = 3'b101; v.shift = 1; end
               default: v.aluop = 3'b000;
            endcase
         end
         7:  begin v.regdst = 2'b01; v.regwrite = !ovf; v.ovf_exc = ovf; end
         8:  begin
            v.alusrca = 1; v.aluop = 3'b110; v.pcwritecond = 1; v.pcsource = 2'b01;
            v.branch = (op == 6'h04);
         end
         9:  begin v.pcsource = 2'b10; v.pcwrite = 1; end
         10: begin
            v.alusrca = 1; v.alusrcb = 2'b10;
            case (op)
               6'h08: v.aluop = 3'b010;
               6'h0A: v.aluop = 3'b111;
               6'h0D: v.aluop = 3'b001;
               default: v.aluop = 3'b000;
            endcase
         end
         11: begin v.regwrite = !ovf; v.ovf_exc = ovf; end
         12: begin v.memtoreg = 2'b10; v.regwrite = 1; end
         13: begin v.regdst = 2'b10; v.memtoreg = 2'b11; v.regwrite = 1; v.pcsource = 2'b10; v.pcwrite = 1; end
         14: begin v.pcsource = 2'b11; v.pcwrite = 1; end
         default: ;
      endcase
      return v;
   endfunction

   // One clock cycle: drive inputs, push the expectation for the current state, advance.
   task automatic applyStimulus(input int st, input bit mio, input bit ov, input bit rst);
      reset = rst;
      MIO_ready = mio;
      overflow = ov;
      zero = rb();
      exp_q.push_back(exp_out(st, Inst, ovf_m, ill_pend));
      ill_pend = 1'b0;
      if (err_chk >= 0) begin
         #1;
         total++;
         if (e_state_out !== err_chk[3:0] || e_illegal_inst !== err_ill) begin
            bad++;
            $display("FAIL err_variant cyc=%0d: state=%0d illegal=%b, required state=%0d illegal=%b",
                     cyc, e_state_out, e_illegal_inst, err_chk, err_ill);
         end
         err_chk = -1;
      end
      @(negedge clk);
   endtask

   task automatic runInst(input logic [31:0] ins, input int if_stall, input int mem_stall,
                          input int ov_mode, input bit rst_mem);
      bit ov;
      int st;
      logic [5:0] op, fn;
      Inst = ins;
      op = ins[31:26];
      fn = ins[5:0];
      ov = (ov_mode == 2) ? rb() : 1'(ov_mode);
      for (int i = 0; i < if_stall; i++) applyStimulus(0, 0, rb(), 0);
      applyStimulus(0, 1, rb(), 0);
      applyStimulus(1, rb(), rb(), 0);
      case (op)
         6'h23, 6'h2B: begin
            applyStimulus(2, rb(), rb(), 0);
            st = (op == 6'h2B) ? 5 : 3;
            if (rst_mem) begin
               applyStimulus(st, 0, rb(), 1);
               ovf_m = 1'b0;
               return;
            end
            for (int i = 0; i < mem_stall; i++) applyStimulus(st, 0, rb(), 0);
            applyStimulus(st, 1, rb(), 0);
            if (st == 3) applyStimulus(4, rb(), rb(), 0);
         end
         6'h00: begin
            if (fn == 6'h08) begin
               applyStimulus(14, rb(), rb(), 0);
            end else begin
               applyStimulus(6, rb(), ov, 0);
               ovf_m = ov && (fn == 6'h20 || fn == 6'h22);
               if (funct_ok(fn)) applyStimulus(7, rb(), rb(), 0);
               else ill_pend = 1'b1;
            end
         end
         6'h04, 6'h05: applyStimulus(8, rb(), rb(), 0);
         6'h02:        applyStimulus(9, rb(), rb(), 0);
         6'h03:        applyStimulus(13, rb(), rb(), 0);
         6'h08, 6'h0A, 6'h0C, 6'h0D: begin
            applyStimulus(10, rb(), ov, 0);
            ovf_m = ov && (op == 6'h08);
            applyStimulus(11, rb(), rb(), 0);
         end
         6'h0F:   applyStimulus(12, rb(), rb(), 0);
         default: ill_pend = 1'b1;
      endcase
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle the DUT presents a full control vector; compare it to the queue.
   task automatic checkOutput(input outv_t e);
      total++;
      if (act !== e) begin
         bad++;
         $display("FAIL ctrl_vec cyc=%0d: got=%h required=%h (state got=%0d required=%0d)",
                  cyc, act, e, act.state, e.state);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         while (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [5:0] ops[13];
      logic [5:0] fns[10];
      logic [31:0] r;
      ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02, 6'h08, 6'h3F};
      reset = 1'b1;
      Inst = '0;
      zero = 1'b0;
      overflow = 1'b0;
      MIO_ready = 1'b0;
      repeat (2) @(negedge clk);

      runInst(32'h8C880004, 0, 0, 2, 0);
      runInst(32'h1085FFFF, 0, 0, 2, 0);
      runInst(32'h1485FFFF, 0, 0, 2, 0);
      runInst(32'hAC880008, 3, 3, 2, 0);
      runInst(32'h8C880004, 3, 3, 2, 0);
      runInst(32'h00851020, 0, 0, 1, 0);
      runInst(32'h00851020, 0, 0, 0, 0);
      runInst(32'h00851022, 0, 0, 1, 0);
      runInst(32'h0085102A, 0, 0, 1, 0);
      runInst(32'h20850001, 0, 0, 1, 0);
      runInst(32'h28850001, 0, 0, 1, 0);
      runInst(32'h0C000010, 0, 0, 2, 0);
      runInst(32'h03E00008, 0, 0, 2, 0);
      runInst(32'h00051082, 0, 0, 2, 0);
      runInst(32'hFC000000, 0, 0, 2, 0);
      runInst(32'h0000003F, 1, 0, 2, 0);
      runInst(32'h3C051234, 0, 0, 2, 0);
      runInst(32'h8C880004, 0, 2, 2, 1);
      runInst(32'hAC880008, 0, 2, 2, 1);

      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         if ($urandom_range(0, 7) == 0) r[31:26] = 6'($urandom);
         else r[31:26] = ops[$urandom_range(0, 12)];
         if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 9)];
         runInst(r, $urandom_range(0, 2), $urandom_range(0, 3), 2, ($urandom_range(0, 19) == 0));
      end

      // Halting variant: reset both, then an illegal opcode must park it in ERR.
      applyStimulus(0, 1, rb(), 1);
      err_chk = 0;
      err_ill = 1'b0;
      runInst(32'hFC000000, 0, 0, 2, 0);
      for (int k = 0; k < 4; k++) begin
         err_chk = 15;
         err_ill = (k == 0);
         applyStimulus(0, (k == 3) ? 1'b0 : rb() & 1'b0, rb(), 0);
      end

      @(negedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: queue size=%0d, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
